noise_trigger_arbiter: RTL and testbench

//   Sequences and shares the single noise_sound channel between the explosion and shell sources.

---
 rtl/noise_ctrl_pkg.sv | 23 ++
 rtl/trig_edge_latch.sv | 39 +++
 rtl/noise_trigger_arbiter.sv | 144 ++++++++++++++
 tb/tb_noise_trigger_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noise_ctrl_pkg.sv
// Shared state encoding, sound-latch bit positions and source codes for the
// noise channel arbiter.
package noise_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    X_TRIG,
    X_HOLD,
    S_TRIG,
    S_HOLD
  } state_t;

  localparam int BIT_EXPL_TRIG  = 0;
  localparam int BIT_EXPL_LOUD  = 1;
  localparam int BIT_SHELL_TRIG = 2;
  localparam int BIT_SHELL_LOUD = 3;
  localparam int BIT_SND_EN     = 5;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_EXPL  = 2'd1;
  localparam logic [1:0] SRC_SHELL = 2'd2;

endpackage

// File: rtl/trig_edge_latch.sv
// Rising-edge catcher for one trigger bit of the sound latch; holds a pending
// request and the loud bit written alongside it until the arbiter consumes it.
module trig_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic wr_en,
  input  logic trig_bit,
  input  logic loud_bit,
  input  logic enable,
  input  logic consume,
  output logic pend,
  output logic loud
);

  logic trig_q;
  logic rise;

  assign rise = wr_en & enable & trig_bit & ~trig_q;

  // A fresh rise outranks a consume in the same cycle so no request is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q <= 1'b0;
      pend   <= 1'b0;
      loud   <= 1'b0;
    end else begin
      if (wr_en) begin
        trig_q <= trig_bit;
      end
      if (rise) begin
        pend <= 1'b1;
        loud <= loud_bit;
      end else if (consume) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/noise_trigger_arbiter.sv
// Shares the noise_sound channel between explosion and shell sources: explosion
// wins and preempts, shell retriggers itself, each owns the channel for a hold window.
module noise_trigger_arbiter
  import noise_ctrl_pkg::*;
#(
  parameter int TRIG_TICKS = 16,
  parameter int EXPL_HOLD  = 16384,
  parameter int SHELL_HOLD = 4096,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_3MHz_en,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       noise_en,
  output logic       loud_soft,
  output logic [1:0] active_src,
  output logic       busy
);

  localparam logic [CNT_W-1:0] TRIG_LOAD  = CNT_W'(TRIG_TICKS - 1);
  localparam logic [CNT_W-1:0] EXPL_LOAD  = CNT_W'(EXPL_HOLD - 1);
  localparam logic [CNT_W-1:0] SHELL_LOAD = CNT_W'(SHELL_HOLD - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             snd_en_q;
  logic             force_idle;
  logic             pend_x;
  logic             pend_s;
  logic             loud_x;
  logic             loud_s;
  logic             consume_x;
  logic             consume_s;
  logic             wr_unused;

  assign wr_unused = ^{wr_data[7:6], wr_data[4]};

  // A write in flight decides the sound enable; otherwise the latched copy does.
  assign force_idle = wr_en ? ~wr_data[BIT_SND_EN] : ~snd_en_q;

  // Every tick with a pending shell consumes it, whether granted or masked.
  assign consume_x = force_idle | (clk_3MHz_en & pend_x);
  assign consume_s = force_idle | (clk_3MHz_en & pend_s);

  trig_edge_latch u_expl (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .trig_bit (wr_data[BIT_EXPL_TRIG]),
    .loud_bit (wr_data[BIT_EXPL_LOUD]),
    .enable   (wr_data[BIT_SND_EN]),
    .consume  (consume_x),
    .pend     (pend_x),
    .loud     (loud_x)
  );

  trig_edge_latch u_shell (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .trig_bit (wr_data[BIT_SHELL_TRIG]),
    .loud_bit (wr_data[BIT_SHELL_LOUD]),
    .enable   (wr_data[BIT_SND_EN]),
    .consume  (consume_s),
    .pend     (pend_s),
    .loud     (loud_s)
  );

  // Arbitration is evaluated ahead of the countdown so a new grant always restarts the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      snd_en_q   <= 1'b0;
      noise_en   <= 1'b0;
      loud_soft  <= 1'b0;
      active_src <= SRC_NONE;
      busy       <= 1'b0;
    end else begin
      if (wr_en) begin
        snd_en_q <= wr_data[BIT_SND_EN];
      end
      if (force_idle) begin
        state      <= IDLE;
        cnt        <= '0;
        noise_en   <= 1'b0;
        active_src <= SRC_NONE;
        busy       <= 1'b0;
      end else if (clk_3MHz_en) begin
        if (pend_x) begin
          state      <= X_TRIG;
          cnt        <= TRIG_LOAD;
          noise_en   <= 1'b1;
          loud_soft  <= loud_x;
          active_src <= SRC_EXPL;
          busy       <= 1'b1;
        end else if (pend_s && state != X_TRIG && state != X_HOLD) begin
          state      <= S_TRIG;
          cnt        <= TRIG_LOAD;
          noise_en   <= 1'b1;
          loud_soft  <= loud_s;
          active_src <= SRC_SHELL;
          busy       <= 1'b1;
        end else begin
          case (state)
            X_TRIG: begin
              if (cnt == '0) begin
                state    <= X_HOLD;
                cnt      <= EXPL_LOAD;
                noise_en <= 1'b0;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
            S_TRIG: begin
              if (cnt == '0) begin
                state    <= S_HOLD;
                cnt      <= SHELL_LOAD;
                noise_en <= 1'b0;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
            X_HOLD, S_HOLD: begin
              if (cnt == '0) begin
                state      <= IDLE;
                active_src <= SRC_NONE;
                busy       <= 1'b0;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
            default: begin
              cnt <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_noise_trigger_arbiter.sv
// Scoreboard bench: expected output changes, stamped with the tick count at which
// they must appear, are queued by the stimulus and popped by a monitor on each change.
module tb_noise_trigger_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_3MHz_en;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       noise_en;
  logic       loud_soft;
  logic [1:0] active_src;
  logic       busy;

  always #5 clk = ~clk;

  noise_trigger_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .clk_3MHz_en (clk_3MHz_en),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .noise_en    (noise_en),
    .loud_soft   (loud_soft),
    .active_src  (active_src),
    .busy        (busy)
  );

  typedef struct {
    int unsigned tick;
    logic [4:0]  val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned tick_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          gate_mode = 1'b0;
  logic [4:0]  prev_obs;

  always @(posedge clk) begin
    if (clk_3MHz_en === 1'b1) tick_cnt <= tick_cnt + 1;
  end

  // loud_soft only matters while noise_en is high, so it is observed through noise_en
  function automatic logic [4:0] obs();
    return {noise_en, noise_en & loud_soft, active_src, busy};
  endfunction

  function automatic logic [4:0] o(input bit ne, input bit ld, input logic [1:0] src, input bit b);
    return {ne, ld, src, b};
  endfunction

  task automatic checkOutput(input string name, input logic [4:0] got, input logic [4:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic checkEvent(input string name, input logic [4:0] got, input logic [4:0] want,
                            input int unsigned got_t, input int unsigned want_t);
    checks++;
    if (got !== want || got_t != want_t) begin
      errors++;
      $display("[TB] FAIL %s: got %b at tick %0d, expected %b at tick %0d",
               name, got, got_t, want, want_t);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] cur;
    exp_t       e;
    if (mon_en) begin
      cur = obs();
      if (cur !== prev_obs) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_change: got %b at tick %0d, expected no change", cur, tick_cnt);
        end else begin
          e = sb.pop_front();
          checkEvent(e.name, cur, e.val, tick_cnt, e.tick);
        end
        prev_obs = cur;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (gate_mode) clk_3MHz_en = ~clk_3MHz_en;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic pushExpect(input int unsigned t, input logic [4:0] v, input string n);
    exp_t e;
    e.tick = t;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic drain(input int limit, input string n);
    int k = 0;
    while (sb.size() != 0 && k < limit) begin
      step();
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d events outstanding, expected 0", n, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish by 1ms, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int unsigned t;
    reset       = 1'b1;
    wr_en       = 1'b0;
    wr_data     = 8'h00;
    clk_3MHz_en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", obs(), 5'b0);
    reset    = 1'b0;
    prev_obs = obs();
    mon_en   = 1'b1;

    $display("[TB] gated ticks: explosion grant, masked shell, mute");
    t = tick_cnt;
    applyStimulus(8'h21);
    steps(4);
    pushExpect(t + 1,  o(1, 0, 1, 1), "a_grant");
    pushExpect(t + 17, o(0, 0, 1, 1), "a_trig_end");
    gate_mode = 1'b1;
    drain(200, "a");
    applyStimulus(8'h24);
    steps(6);
    checkOutput("a_xhold_shell_masked", obs(), o(0, 0, 1, 1));
    gate_mode   = 1'b0;
    clk_3MHz_en = 1'b1;
    pushExpect(tick_cnt + 1, 5'b0, "a_mute");
    applyStimulus(8'h00);
    drain(20, "a_mute");

    $display("[TB] explosion full sequence, loud");
    t = tick_cnt;
    pushExpect(t + 2,          o(1, 1, 1, 1), "b_grant");
    pushExpect(t + 18,         o(0, 0, 1, 1), "b_trig_end");
    pushExpect(t + 18 + 16384, 5'b0,          "b_idle");
    applyStimulus(8'h23);
    drain(17000, "b");

    $display("[TB] shell retrigger");
    t = tick_cnt;
    pushExpect(t + 2, o(1, 0, 2, 1), "c_grant");
    applyStimulus(8'h24);
    steps(2);
    applyStimulus(8'h20);
    while (tick_cnt < t + 10) step();
    pushExpect(t + 28,        o(0, 0, 2, 1), "c_trig_end_26");
    pushExpect(t + 28 + 4096, 5'b0,          "c_idle");
    applyStimulus(8'h24);
    drain(5000, "c");

    $display("[TB] explosion preempts loud shell");
    applyStimulus(8'h20);
    t = tick_cnt;
    pushExpect(t + 2, o(1, 1, 2, 1), "d_shell_grant");
    applyStimulus(8'h2C);
    steps(4);
    t = tick_cnt;
    pushExpect(t + 2,  o(1, 0, 1, 1), "d_preempt");
    pushExpect(t + 18, o(0, 0, 1, 1), "d_trig_end");
    applyStimulus(8'h21);
    drain(100, "d");
    applyStimulus(8'h24);
    steps(5);
    checkOutput("d_shell_masked", obs(), o(0, 0, 1, 1));
    pushExpect(tick_cnt + 1, 5'b0, "d_mute");
    applyStimulus(8'h00);
    drain(20, "d_mute");

    $display("[TB] mute mid trigger window, then regrant");
    t = tick_cnt;
    pushExpect(t + 2, o(1, 0, 1, 1), "e_grant");
    applyStimulus(8'h21);
    steps(5);
    pushExpect(tick_cnt + 1, 5'b0, "e_mute");
    applyStimulus(8'h00);
    drain(10, "e_mute");
    t = tick_cnt;
    pushExpect(t + 2, o(1, 0, 1, 1), "e_regrant");
    applyStimulus(8'h21);
    drain(10, "e_regrant");

    $display("[TB] reset mid operation");
    steps(3);
    pushExpect(tick_cnt + 1, 5'b0, "g_reset");
    reset = 1'b1;
    step();
    reset = 1'b0;
    drain(10, "g");

    $display("[TB] simultaneous explosion and shell");
    t = tick_cnt;
    pushExpect(t + 2,          o(1, 0, 1, 1), "f_grant");
    pushExpect(t + 18,         o(0, 0, 1, 1), "f_trig_end");
    pushExpect(t + 18 + 16384, 5'b0,          "f_idle");
    applyStimulus(8'h25);
    drain(17000, "f");
    steps(50);
    checkOutput("f_no_shell", obs(), 5'b0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
